// File: rtl/count_rate_if.sv
// count_rate_if: valid/ready bus that carries one delta sample.
// The master drives out_valid and out_delta; the slave drives out_ready.
interface count_rate_if #(
   parameter int WIDTH = 8
);

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_delta;

   modport master (
      output out_valid,
      output out_delta,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_delta,
      output out_ready
   );

endinterface

// File: rtl/count_rate_monitor.sv
// count_rate_monitor: measures how far a remote Gray counter advances
// over a fixed window of local clock cycles.
//
// The remote count is synchronized into the local clock domain and
// converted to binary. Every WINDOW cycles the count advance is taken
// modulo 2^WIDTH and offered on a one-entry valid/ready output.
//
// Ports
//   clk        local clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   cnt_gray   remote Gray-coded count, asynchronous to clk
//   ob         output bus: out_valid, out_delta (driven), out_ready (input)
//   drop_count samples discarded because the output was full (saturates)
module count_rate_monitor #(
   parameter int WIDTH       = 8,
   parameter int WINDOW      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_gray,
   count_rate_if.master     ob,
   output logic [7:0]       drop_count
);

   localparam int FC_W = $clog2(SYNC_STAGES);
   localparam int WC_W = $clog2(WINDOW);

   localparam logic [FC_W-1:0] FILL_LAST = FC_W'(SYNC_STAGES - 1);
   localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WINDOW - 1);

   localparam logic [1:0] ST_FILL = 2'd0;
   localparam logic [1:0] ST_BASE = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   // ---------------------------------------------------------------
   // Synchronizer: a plain flop chain, nothing between the stages.
   // Gray coding keeps each capture within one count of the truth.
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= cnt_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // ---------------------------------------------------------------
   // Gray to binary: each binary bit is the XOR of all Gray bits at
   // and above its position.
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] sync_last;
   logic [WIDTH-1:0] cur_bin;

   assign sync_last = sync_q[SYNC_STAGES-1];

   always_comb begin
      cur_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cur_bin[i] = ^(sync_last >> i);
      end
   end

   // ---------------------------------------------------------------
   // Window sequencer.
   // FILL waits for the synchronizer to hold real data, BASE takes
   // the first reference count, RUN closes a window every WINDOW
   // cycles. A window end is registered (wend_q/wdelta_q) and handed
   // to the output stage on the following edge.
   // ---------------------------------------------------------------
   logic [1:0]       state;
   logic [FC_W-1:0]  fill_cnt;
   logic [WC_W-1:0]  win_cnt;
   logic [WIDTH-1:0] prev;
   logic             wend_q;
   logic [WIDTH-1:0] wdelta_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FILL;
         fill_cnt <= '0;
         win_cnt  <= '0;
         prev     <= '0;
         wend_q   <= 1'b0;
         wdelta_q <= '0;
      end else begin
         wend_q <= 1'b0;
         unique case (state)
            ST_FILL: begin
               fill_cnt <= fill_cnt + FC_W'(1);
               if (fill_cnt == FILL_LAST) begin
                  state <= ST_BASE;
               end
            end
            ST_BASE: begin
               prev    <= cur_bin;
               win_cnt <= '0;
               state   <= ST_RUN;
            end
            ST_RUN: begin
               if (win_cnt == WIN_LAST) begin
                  // Modular difference stays correct across counter wrap.
                  wdelta_q <= cur_bin - prev;
                  wend_q   <= 1'b1;
                  prev     <= cur_bin;
                  win_cnt  <= '0;
               end else begin
                  win_cnt <= win_cnt + WC_W'(1);
               end
            end
            default: begin
               state <= ST_FILL;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // One-entry output register. A slot being drained this cycle
   // counts as free, so a window end that coincides with a handshake
   // replaces the sample without a drop and without a valid bubble.
   // out_valid depends only on registered state.
   // ---------------------------------------------------------------
   logic drain;
   logic slot_free;

   assign drain     = ob.out_valid & ob.out_ready;
   assign slot_free = ~ob.out_valid | ob.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         ob.out_valid <= 1'b0;
         ob.out_delta <= '0;
         drop_count   <= '0;
      end else if (wend_q) begin
         if (slot_free) begin
            ob.out_valid <= 1'b1;
            ob.out_delta <= wdelta_q;
         end else if (drop_count != 8'd255) begin
            drop_count <= drop_count + 8'd1;
         end
      end else if (drain) begin
         ob.out_valid <= 1'b0;
      end
   end

endmodule
